// File: rtl/usb_tx_pkg.sv
// Shared types for the USB TX arbiter: tx_top command codes, handshake types,
// arbiter states and the latched grant payload.
package usb_tx_pkg;

    typedef enum logic [2:0] {
        TXP_IDLE  = 3'd0,
        TXP_DATA0 = 3'd1,
        TXP_DATA1 = 3'd2,
        TXP_ACK   = 3'd3,
        TXP_NAK   = 3'd4,
        TXP_STALL = 3'd5
    } tx_packet_t;

    typedef enum logic [1:0] {
        HS_ACK   = 2'd0,
        HS_NAK   = 2'd1,
        HS_STALL = 2'd2,
        HS_RSVD  = 2'd3
    } hs_type_t;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_ISSUE,
        ARB_ACTIVE,
        ARB_REPORT
    } arb_state_t;

    // Request captured at grant time: who asked (0=handshake, 1=data) and what to send.
    typedef struct packed {
        logic       src;
        tx_packet_t code;
    } txn_t;

    function automatic tx_packet_t hs_packet(input hs_type_t t);
        case (t)
            HS_ACK:   return TXP_ACK;
            HS_NAK:   return TXP_NAK;
            HS_STALL: return TXP_STALL;
            default:  return TXP_IDLE;
        endcase
    endfunction

    function automatic tx_packet_t data_packet(input logic pid);
        return pid ? TXP_DATA1 : TXP_DATA0;
    endfunction

endpackage

// File: rtl/usb_tx_watchdog.sv
// Start-timeout counter: counts while enabled, flags the last allowed cycle,
// saturates there until cleared.
module usb_tx_watchdog #(
    parameter int unsigned LIMIT = 16,
    parameter int unsigned W     = $clog2(LIMIT + 1)
) (
    input  logic clk,
    input  logic n_rst,
    input  logic clear,
    input  logic enable,
    output logic expired_c
);

    logic [W-1:0] count_q;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            count_q <= '0;
        end else if (clear) begin
            count_q <= '0;
        end else if (enable && !expired_c) begin
            count_q <= count_q + W'(1);
        end
    end

    assign expired_c = (count_q == W'(LIMIT - 1));

endmodule

// File: rtl/usb_tx_arbiter.sv
// Shares the USB TX path between handshake and data requesters, sequences
// tx_top and reports completion. Define TX_ARB_RETRY_EN to re-send failed data packets.
module usb_tx_arbiter
    import usb_tx_pkg::*;
#(
    parameter int unsigned START_TIMEOUT = 16
`ifdef TX_ARB_RETRY_EN
    ,
    parameter int unsigned MAX_RETRY = 2
`endif
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       hs_req,
    input  logic [1:0] hs_type,
    input  logic       data_req,
    input  logic       data_pid,
    input  logic       TX_Transfer_Active,
    input  logic       tx_error,
    output logic [2:0] tx_packet,
    output logic       hs_grant,
    output logic       data_grant,
    output logic       tx_done,
    output logic       tx_fail,
    output logic       done_src,
    output logic       busy
);

    localparam int unsigned TIMER_W = $clog2(START_TIMEOUT + 1);
`ifdef TX_ARB_RETRY_EN
    localparam int unsigned RETRY_W = $clog2(MAX_RETRY + 1);
    logic [RETRY_W-1:0] retry_q, retry_d;
`endif

    arb_state_t state_q, state_d;
    tx_packet_t tx_packet_q, tx_packet_d;
    txn_t       txn_q, txn_d;
    logic       fail_q, fail_d;
    logic       rsvd_q, rsvd_d;
    logic       tta_q;
    logic       hs_grant_d, data_grant_d, tx_done_d, tx_fail_d, done_src_d;
    logic       finish_c, finish_fail_c, retry_ok_c, resend_c;
    logic       expired_c, wd_clear_c;

    usb_tx_watchdog #(
        .LIMIT (START_TIMEOUT),
        .W     (TIMER_W)
    ) u_watchdog (
        .clk       (clk),
        .n_rst     (n_rst),
        .clear     (wd_clear_c),
        .enable    (state_q == ARB_ISSUE),
        .expired_c (expired_c)
    );

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q     <= ARB_IDLE;
            tx_packet_q <= TXP_IDLE;
            txn_q       <= '0;
            fail_q      <= 1'b0;
            rsvd_q      <= 1'b0;
            tta_q       <= 1'b0;
            hs_grant    <= 1'b0;
            data_grant  <= 1'b0;
            tx_done     <= 1'b0;
            tx_fail     <= 1'b0;
            done_src    <= 1'b0;
            busy        <= 1'b0;
`ifdef TX_ARB_RETRY_EN
            retry_q     <= '0;
`endif
        end else begin
            state_q     <= state_d;
            tx_packet_q <= tx_packet_d;
            txn_q       <= txn_d;
            fail_q      <= fail_d;
            rsvd_q      <= rsvd_d;
            tta_q       <= TX_Transfer_Active;
            hs_grant    <= hs_grant_d;
            data_grant  <= data_grant_d;
            tx_done     <= tx_done_d;
            tx_fail     <= tx_fail_d;
            done_src    <= done_src_d;
            busy        <= (state_d != ARB_IDLE);
`ifdef TX_ARB_RETRY_EN
            retry_q     <= retry_d;
`endif
        end
    end

    always_comb begin
        state_d       = state_q;
        tx_packet_d   = tx_packet_q;
        txn_d         = txn_q;
        fail_d        = fail_q;
        rsvd_d        = rsvd_q;
        hs_grant_d    = 1'b0;
        data_grant_d  = 1'b0;
        tx_done_d     = 1'b0;
        tx_fail_d     = 1'b0;
        done_src_d    = 1'b0;
        finish_c      = 1'b0;
        finish_fail_c = 1'b0;
        resend_c      = 1'b0;
`ifdef TX_ARB_RETRY_EN
        retry_d       = retry_q;
        retry_ok_c    = txn_q.src && (retry_q < RETRY_W'(MAX_RETRY));
`else
        retry_ok_c    = 1'b0;
`endif

        case (state_q)
            ARB_IDLE: begin
                if (hs_req) begin
                    hs_grant_d = 1'b1;
                    txn_d.src  = 1'b0;
                    fail_d     = 1'b0;
                    if (hs_type_t'(hs_type) == HS_RSVD) begin
                        // Reserved type is granted but never reaches tx_top.
                        txn_d.code = TXP_IDLE;
                        rsvd_d     = 1'b1;
                        state_d    = ARB_REPORT;
                    end else begin
                        txn_d.code  = hs_packet(hs_type_t'(hs_type));
                        tx_packet_d = txn_d.code;
                        state_d     = ARB_ISSUE;
                    end
                end else if (data_req) begin
                    data_grant_d = 1'b1;
                    txn_d.src    = 1'b1;
                    txn_d.code   = data_packet(data_pid);
                    tx_packet_d  = txn_d.code;
                    fail_d       = 1'b0;
                    state_d      = ARB_ISSUE;
                end
            end
            ARB_ISSUE: begin
                // A start seen on the last allowed cycle still counts as a start.
                if (tx_error || (expired_c && !TX_Transfer_Active)) begin
                    finish_c      = 1'b1;
                    finish_fail_c = 1'b1;
                end else if (TX_Transfer_Active) begin
                    tx_packet_d = TXP_IDLE;
                    state_d     = ARB_ACTIVE;
                end
            end
            ARB_ACTIVE: begin
                if (tx_error) begin
                    fail_d = 1'b1;
                end
                if (tta_q && !TX_Transfer_Active) begin
                    finish_c      = 1'b1;
                    finish_fail_c = fail_q | tx_error;
                end
            end
            ARB_REPORT: begin
                // Reserved handshake: pulse fail one cycle after its grant.
                if (rsvd_q) begin
                    rsvd_d     = 1'b0;
                    tx_fail_d  = 1'b1;
                    done_src_d = txn_q.src;
                end else begin
                    state_d = ARB_IDLE;
                end
            end
            default: state_d = ARB_IDLE;
        endcase

        if (finish_c) begin
            if (finish_fail_c && retry_ok_c) begin
                state_d     = ARB_ISSUE;
                tx_packet_d = txn_q.code;
                fail_d      = 1'b0;
                resend_c    = 1'b1;
`ifdef TX_ARB_RETRY_EN
                retry_d     = RETRY_W'(retry_q + RETRY_W'(1));
`endif
            end else begin
                state_d     = ARB_REPORT;
                tx_packet_d = TXP_IDLE;
                tx_done_d   = !finish_fail_c;
                tx_fail_d   = finish_fail_c;
                done_src_d  = txn_q.src;
`ifdef TX_ARB_RETRY_EN
                retry_d     = '0;
`endif
            end
        end

        wd_clear_c = (state_q != ARB_ISSUE) || resend_c;
    end

    assign tx_packet = tx_packet_q;

endmodule

// File: tb/tb_usb_tx_arbiter.sv
// Randomized bench for usb_tx_arbiter: plans each scene as a per-cycle timeline
// from transaction-level rules, drives tx_top behaviour from it and compares outputs.
module tb_usb_tx_arbiter;

    localparam int unsigned START_TIMEOUT = 16;
    localparam int unsigned MAX_RETRY     = 2;
    localparam int MAXC     = 512;
    localparam int N_SCENES = 60;
`ifdef TX_ARB_RETRY_EN
    localparam bit RETRY_ON = 1'b1;
`else
    localparam bit RETRY_ON = 1'b0;
`endif

    localparam int PK_OK        = 0;
    localparam int PK_ACT_ERR   = 1;
    localparam int PK_ISSUE_ERR = 2;
    localparam int PK_TIMEOUT   = 3;

    // tx_top behaviour per attempt: start delay d, active length l, error offset e.
    typedef struct {
        int kind;
        int d;
        int l;
        int e;
    } prof_t;

    logic       tb_clk = 1'b0;
    logic       n_rst;
    logic       hs_req;
    logic [1:0] hs_type;
    logic       data_req;
    logic       data_pid;
    logic       tta;
    logic       tx_error;
    logic [2:0] tx_packet;
    logic       hs_grant, data_grant, tx_done, tx_fail, done_src, busy;

    int n_checks = 0;
    int n_pass   = 0;

    int exp_pkt[MAXC];
    int exp_hsg[MAXC];
    int exp_dg[MAXC];
    int exp_done[MAXC];
    int exp_fail[MAXC];
    int exp_src[MAXC];
    int exp_busy[MAXC];
    int drv_hs[MAXC];
    int drv_dr[MAXC];
    int drv_tta[MAXC];
    int drv_err[MAXC];

    usb_tx_arbiter dut (
        .clk                (tb_clk),
        .n_rst              (n_rst),
        .hs_req             (hs_req),
        .hs_type            (hs_type),
        .data_req           (data_req),
        .data_pid           (data_pid),
        .TX_Transfer_Active (tta),
        .tx_error           (tx_error),
        .tx_packet          (tx_packet),
        .hs_grant           (hs_grant),
        .data_grant         (data_grant),
        .tx_done            (tx_done),
        .tx_fail            (tx_fail),
        .done_src           (done_src),
        .busy               (busy)
    );

    always #5 tb_clk = ~tb_clk;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    endtask

    function automatic int hs_code(input int typ);
        case (typ)
            0:       return 3;
            1:       return 4;
            2:       return 5;
            default: return 0;
        endcase
    endfunction

    task automatic clear_plan();
        for (int i = 0; i < MAXC; i++) begin
            exp_pkt[i] = 0; exp_hsg[i] = 0; exp_dg[i] = 0; exp_done[i] = 0;
            exp_fail[i] = 0; exp_src[i] = 0; exp_busy[i] = 0;
            drv_hs[i] = 0; drv_dr[i] = 0; drv_tta[i] = 0; drv_err[i] = 0;
        end
    endtask

    // Plan one granted request seen in IDLE cycle t; returns grant cycle and next IDLE cycle.
    task automatic serve(input bit is_data, input int typ, input int pid, input prof_t p,
                         input int t, output int g, output int t_next);
        int  e_c, r_c, code, att, last_pkt;
        bit  failed, finished;
        g = t + 1;
        t_next = g + 1;
        if (is_data) exp_dg[g] = 1;
        else exp_hsg[g] = 1;
        code = is_data ? (pid != 0 ? 2 : 1) : hs_code(typ);
        if (!is_data && typ == 3) begin
            exp_busy[g] = 1;
            exp_busy[g+1] = 1;
            exp_fail[g+1] = 1;
            t_next = g + 2;
            return;
        end
        e_c = g;
        att = 0;
        finished = 1'b0;
        while (!finished) begin
            if (p.kind == PK_TIMEOUT) begin
                last_pkt = e_c + int'(START_TIMEOUT) - 1;
                r_c = e_c + int'(START_TIMEOUT);
                failed = 1'b1;
            end else if (p.kind == PK_ISSUE_ERR) begin
                drv_err[e_c + p.e] = 1;
                last_pkt = e_c + p.e;
                r_c = e_c + p.e + 1;
                failed = 1'b1;
            end else begin
                for (int k = 0; k < p.l; k++) drv_tta[e_c + p.d + k] = 1;
                last_pkt = e_c + p.d;
                r_c = e_c + p.d + p.l + 1;
                failed = (p.kind == PK_ACT_ERR);
                if (failed) drv_err[e_c + p.d + p.e] = 1;
            end
            for (int c = e_c; c <= last_pkt; c++) exp_pkt[c] = code;
            for (int c = e_c; c < r_c; c++) exp_busy[c] = 1;
            if (failed && is_data && RETRY_ON && att < int'(MAX_RETRY)) begin
                att++;
                e_c = r_c;
            end else begin
                exp_busy[r_c] = 1;
                if (failed) exp_fail[r_c] = 1;
                else exp_done[r_c] = 1;
                exp_src[r_c] = is_data ? 1 : 0;
                t_next = r_c + 1;
                finished = 1'b1;
            end
        end
    endtask

    function automatic prof_t gen_prof();
        prof_t p;
        int r;
        r = int'($urandom_range(0, 9));
        p.kind = PK_OK;
        p.d = int'($urandom_range(0, 15));
        p.l = int'($urandom_range(1, 12));
        p.e = 0;
        if (r == 9) begin
            p.d = 15;
        end else if (r == 5 || r == 6) begin
            p.kind = PK_ACT_ERR;
            p.e = int'($urandom_range(1, p.l));
        end else if (r == 7) begin
            p.kind = PK_ISSUE_ERR;
            p.d = int'($urandom_range(1, 15));
            p.e = int'($urandom_range(0, p.d - 1));
        end else if (r == 8) begin
            p.kind = PK_TIMEOUT;
        end
        return p;
    endfunction

    // kind: 0 hs, 1 data, 2 both at once, 3 data queued while busy, 4 data withdrawn while busy
    task automatic run_scene(input int sc, input int kind, input int typ, input int pid,
                             input prof_t ph, input prof_t pd);
        int gh, gd, th, t_end, n_cyc;
        string pre;
        clear_plan();
        gh = 0; th = 0; gd = 0; t_end = 0;
        case (kind)
            0: begin
                serve(1'b0, typ, 0, ph, 0, gh, t_end);
                for (int c = 0; c <= gh; c++) drv_hs[c] = 1;
            end
            1: begin
                serve(1'b1, 0, pid, pd, 0, gd, t_end);
                for (int c = 0; c <= gd; c++) drv_dr[c] = 1;
            end
            2, 3: begin
                serve(1'b0, typ, 0, ph, 0, gh, th);
                serve(1'b1, 0, pid, pd, th, gd, t_end);
                for (int c = 0; c <= gh; c++) drv_hs[c] = 1;
                for (int c = (kind == 2 ? 0 : gh + 1); c <= gd; c++) drv_dr[c] = 1;
            end
            default: begin
                serve(1'b0, typ, 0, ph, 0, gh, t_end);
                for (int c = 0; c <= gh; c++) drv_hs[c] = 1;
                for (int c = gh + 1; c <= t_end - 2; c++) drv_dr[c] = 1;
            end
        endcase
        n_cyc = t_end + 3;
        hs_type = 2'(typ);
        data_pid = pid[0];
        for (int c = 0; c < n_cyc; c++) begin
            @(posedge tb_clk);
            #1;
            hs_req   = drv_hs[c][0];
            data_req = drv_dr[c][0];
            tta      = drv_tta[c][0];
            tx_error = drv_err[c][0];
            @(negedge tb_clk);
            pre = $sformatf("s%0d c%0d", sc, c);
            check({pre, " tx_packet"}, int'(tx_packet), exp_pkt[c]);
            check({pre, " hs_grant"}, int'(hs_grant), exp_hsg[c]);
            check({pre, " data_grant"}, int'(data_grant), exp_dg[c]);
            check({pre, " tx_done"}, int'(tx_done), exp_done[c]);
            check({pre, " tx_fail"}, int'(tx_fail), exp_fail[c]);
            check({pre, " busy"}, int'(busy), exp_busy[c]);
            if (exp_done[c] != 0 || exp_fail[c] != 0)
                check({pre, " done_src"}, int'(done_src), exp_src[c]);
        end
    endtask

    task automatic check_quiet(input string tag);
        check({tag, " tx_packet"}, int'(tx_packet), 0);
        check({tag, " hs_grant"}, int'(hs_grant), 0);
        check({tag, " data_grant"}, int'(data_grant), 0);
        check({tag, " tx_done"}, int'(tx_done), 0);
        check({tag, " tx_fail"}, int'(tx_fail), 0);
        check({tag, " done_src"}, int'(done_src), 0);
        check({tag, " busy"}, int'(busy), 0);
    endtask

    initial begin
        int kind, typ, pid;
        prof_t ph, pd;

        n_rst = 1'b0;
        hs_req = 1'b0; hs_type = 2'd0; data_req = 1'b0; data_pid = 1'b0;
        tta = 1'b0; tx_error = 1'b0;
        repeat (2) @(posedge tb_clk);
        @(negedge tb_clk);
        check_quiet("reset");
        n_rst = 1'b1;

        // Reset asserted mid-clock during a grant cycle clears everything at once.
        @(posedge tb_clk); #1;
        data_req = 1'b1; data_pid = 1'b1;
        @(posedge tb_clk); #1;
        data_req = 1'b0; tta = 1'b1;
        @(negedge tb_clk);
        check("pre-abort data_grant", int'(data_grant), 1);
        check("pre-abort tx_packet", int'(tx_packet), 2);
        #2 n_rst = 1'b0;
        #1 check_quiet("async reset");
        tta = 1'b0;
        repeat (2) @(posedge tb_clk);
        @(negedge tb_clk);
        n_rst = 1'b1;
        repeat (4) begin
            @(negedge tb_clk);
            check_quiet("after abort");
        end

        run_scene(0, 0, 0, 0, '{PK_OK, 3, 10, 0}, '{PK_OK, 0, 1, 0});
        run_scene(1, 2, 1, 1, '{PK_OK, 2, 4, 0}, '{PK_OK, 0, 5, 0});
        run_scene(2, 1, 0, 0, '{PK_OK, 0, 1, 0}, '{PK_TIMEOUT, 0, 0, 0});
        run_scene(3, 1, 0, 0, '{PK_OK, 0, 1, 0}, '{PK_ACT_ERR, 2, 6, 3});
        run_scene(4, 0, 3, 0, '{PK_OK, 0, 1, 0}, '{PK_OK, 0, 1, 0});
        run_scene(5, 4, 2, 0, '{PK_OK, 5, 6, 0}, '{PK_OK, 0, 1, 0});
        run_scene(6, 1, 0, 1, '{PK_OK, 0, 1, 0}, '{PK_OK, 15, 3, 0});
        run_scene(7, 3, 3, 0, '{PK_OK, 0, 1, 0}, '{PK_ISSUE_ERR, 4, 2, 1});

        for (int s = 8; s < N_SCENES; s++) begin
            kind = int'($urandom_range(0, 4));
            typ  = int'($urandom_range(0, 3));
            pid  = int'($urandom_range(0, 1));
            if (kind == 4 && typ == 3) typ = 0;
            ph = gen_prof();
            pd = gen_prof();
            run_scene(s, kind, typ, pid, ph, pd);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/usb_tx_arbiter.md
Name: usb_tx_arbiter

Overview:
Sequences the USB TX path (tx_top) and shares it between two requesters: the RX protocol controller, which sends handshake packets, and the AHB-side data engine, which sends DATA0/DATA1 packets. It grants one request at a time and drives the tx_packet command. It tracks TX_Transfer_Active and tx_error through the transfer, then reports completion or failure to the requester that was granted. Handshake requests have priority because of the USB bus turnaround limits.

Parameters:
START_TIMEOUT, 16, cycles to wait for TX_Transfer_Active to rise after a command is issued before the transfer is declared failed
MAX_RETRY, 2, number of data-packet re-sends after a failure (used only with TX_ARB_RETRY_EN)
TIMER_W, $clog2(START_TIMEOUT+1), width of the timeout counter

Ports:
clk  in  1  system clock
n_rst  in  1  reset, asynchronous, active-low
hs_req  in  1  handshake request; level, held until hs_grant
hs_type  in  2  0=ACK 1=NAK 2=STALL 3=reserved; sampled at grant
data_req  in  1  data packet request; level, held until data_grant
data_pid  in  1  0=DATA0 1=DATA1; sampled at grant
TX_Transfer_Active  in  1  from tx_top
tx_error  in  1  from tx_top
tx_packet  out  3  command to tx_top
hs_grant  out  1  1-cycle pulse, handshake request accepted
data_grant  out  1  1-cycle pulse, data request accepted
tx_done  out  1  1-cycle pulse, transfer completed cleanly
tx_fail  out  1  1-cycle pulse, transfer failed
done_src  out  1  0=handshake 1=data; valid while tx_done or tx_fail is high
busy  out  1  high in any state other than IDLE

Behaviour:
- Decided: one clock, clk; reset is asynchronous, active-low, named n_rst.
- Reset values: tx_packet=TXP_IDLE (0), all pulse outputs=0, busy=0, done_src=0, timer=0, retry count=0.
- Reset asserted mid-operation forces IDLE at once. No completion pulse is issued for the aborted transfer.
- Registered FSM with states IDLE, ISSUE, ACTIVE, REPORT.
- IDLE:
  - hs_req=1: pulse hs_grant, latch hs_type, move to ISSUE. Priority goes to hs_req when both requests are high.
  - Otherwise data_req=1: pulse data_grant, latch data_pid, move to ISSUE.
  - Grant pulses are registered and appear in the cycle the state becomes ISSUE.
  - hs_type=3: grant is still given, but the FSM goes straight to REPORT with fail.
- ISSUE:
  - tx_packet holds the latched code; the timer increments each cycle.
  - TX_Transfer_Active=1 moves to ACTIVE, with tx_packet=TXP_IDLE from the next cycle on.
  - tx_error=1 or timer==START_TIMEOUT-1 moves to REPORT with fail.
- ACTIVE:
  - tx_error=1 in any cycle sets a sticky fail flag.
  - Falling edge of TX_Transfer_Active (registered sample was 1, input now 0) moves to REPORT.
- REPORT: pulses tx_done or tx_fail for one cycle with done_src, then returns to IDLE. Earliest next grant is one cycle after REPORT.
- Requests arriving while busy=1 wait and are not dropped. Deasserting a request before its grant withdraws it.
- Packet code map: ACK=3, NAK=4, STALL=5, DATA0=1, DATA1=2.

Optional Feature:
TX_ARB_RETRY_EN
- Defined: a data-packet failure reached from ISSUE or ACTIVE goes back to ISSUE with the same PID and the timer cleared. The retry counter increments on each re-send. tx_fail is issued only after MAX_RETRY re-sends; tx_done clears the counter. Handshake failures are never retried.
- Undefined: every failure goes to REPORT with fail, and the retry counter is not synthesized.

Decomposition:
- Package usb_tx_pkg holds:
  - typedef enum logic [2:0] tx_packet_t: TXP_IDLE, TXP_DATA0, TXP_DATA1, TXP_ACK, TXP_NAK, TXP_STALL
  - typedef enum logic [1:0] hs_type_t
  - typedef enum for the arbiter states
- Sub-module: usb_tx_watchdog, a start-timeout counter with clear/enable inputs and an expired output, used by the ISSUE state.

Test Plan:
- Reset with n_rst=0 applied mid-clock -> tx_packet=0, busy=0, all pulses 0, with no clock edge needed.
- hs_req=1, hs_type=0 -> hs_grant pulses at the next edge; tx_packet=3 until TX_Transfer_Active rises; after 10 active cycles TX_Transfer_Active falls -> tx_done=1 with done_src=0 for 1 cycle, then busy=0.
- hs_req and data_req raised in the same cycle -> the handshake is granted first; data_grant pulses 1 cycle after the handshake REPORT; tx_packet=2 for data_pid=1.
- data_req with TX_Transfer_Active held at 0 -> tx_fail exactly START_TIMEOUT cycles after ISSUE entry; tx_packet returns to 0.
- DATA0 transfer with tx_error pulsed mid-ACTIVE:
  - Macro off -> tx_fail with done_src=1.
  - Macro on -> tx_packet=1 reissued MAX_RETRY times, then tx_fail.
- hs_type=3 -> hs_grant, then tx_fail 1 cycle later; tx_packet never leaves 0.
